ex_mem_stage: RTL and testbench

- Pipeline stage directly downstream of the ALU.
- Registers the ALU result and destination info into the EX/MEM boundary.
- Owns the architectural condition-flag register (Z, V, N) and resolves conditional branches against it.
- Produces a registered branch-taken/redirect indication for the fetch stage. Supports stall (hold) and flush (kill) from the hazard unit.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/branch_cond_eval.sv | 33 +++
 rtl/ex_mem_stage.sv | 133 +++++++++++++
 tb/tb_ex_mem_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Types and constants shared by the EX/MEM pipeline stage, the
//                ALU and the branch condition evaluator.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Branch condition codes as carried in the instruction word
    typedef enum logic [2:0] {
        BR_NE = 3'b000,
        BR_EQ = 3'b001,
        BR_GT = 3'b010,
        BR_LT = 3'b011,
        BR_GE = 3'b100,
        BR_LE = 3'b101,
        BR_OV = 3'b110,
        BR_UN = 3'b111
    } br_cond_e;

    // Architectural condition flags; bit order {z, v, n}
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    // Opcode encodings shared with the ALU
    localparam int unsigned CPU_OPC_W = 5;
    localparam logic [CPU_OPC_W-1:0] OP_NOP = 5'h00;
    localparam logic [CPU_OPC_W-1:0] OP_ADD = 5'h01;
    localparam logic [CPU_OPC_W-1:0] OP_SUB = 5'h02;
    localparam logic [CPU_OPC_W-1:0] OP_AND = 5'h03;
    localparam logic [CPU_OPC_W-1:0] OP_OR  = 5'h04;
    localparam logic [CPU_OPC_W-1:0] OP_XOR = 5'h05;
    localparam logic [CPU_OPC_W-1:0] OP_CMP = 5'h06;
    localparam logic [CPU_OPC_W-1:0] OP_LD  = 5'h08;
    localparam logic [CPU_OPC_W-1:0] OP_ST  = 5'h09;
    localparam logic [CPU_OPC_W-1:0] OP_BR  = 5'h10;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond_eval
//  Description : Combinational evaluation of a branch condition code against
//                the condition flags.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_cond_eval
    import cpu_pkg::*;
(
    input  flags_t   flags_i,
    input  br_cond_e cond_i,
    output logic     taken_o
);

    // Decode the condition code into a taken/not-taken decision
    always_comb begin
        taken_o = 1'b0;
        unique case (cond_i)
            BR_NE: taken_o = ~flags_i.z;
            BR_EQ: taken_o =  flags_i.z;
            BR_GT: taken_o = ~flags_i.z & ~flags_i.n;
            BR_LT: taken_o =  flags_i.n;
            BR_GE: taken_o =  flags_i.z | ~flags_i.n;
            BR_LE: taken_o =  flags_i.n |  flags_i.z;
            BR_OV: taken_o =  flags_i.v;
            BR_UN: taken_o =  1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX/MEM pipeline register. Captures the ALU result and
//                destination info, owns the condition-flag register and
//                resolves conditional branches into a registered redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned OPC_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_n,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  rd,
    input  logic              wb_en,
    input  logic              set_flags,
    input  logic              br_en,
    input  logic [2:0]        br_cond,
    input  logic [DATA_W-1:0] br_target,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wb_en,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_pc
);

    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [REG_W-1:0]  rd_q,     rd_d;
    logic              wb_en_q,  wb_en_d;
    flags_t            flags_q,  flags_d;
    logic              taken_q,  taken_d;
    logic [DATA_W-1:0] pc_q,     pc_d;

    logic              cond_taken;

    // Branches resolve against the flags as registered before this cycle
    branch_cond_eval u_cond (
        .flags_i (flags_q),
        .cond_i  (br_cond_e'(br_cond)),
        .taken_o (cond_taken)
    );

    // Next-state: flush kills, stall holds, otherwise capture or bubble
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        wb_en_d  = wb_en_q;
        flags_d  = flags_q;
        taken_d  = taken_q;
        pc_d     = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            wb_en_d = 1'b0;
            taken_d = 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                valid_d  = 1'b1;
                result_d = alu_result;
                opcode_d = opcode;
                rd_d     = rd;
                wb_en_d  = wb_en;
                taken_d  = br_en & cond_taken;
                if (br_en) begin
                    pc_d = br_target;
                end
                if (set_flags) begin
                    flags_d = '{z: alu_z, v: alu_v, n: alu_n};
                end
            end else begin
                valid_d = 1'b0;
                wb_en_d = 1'b0;
                taken_d = 1'b0;
            end
        end
    end

    // Stage and flag registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
            wb_en_q  <= 1'b0;
            flags_q  <= '0;
            taken_q  <= 1'b0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            wb_en_q  <= wb_en_d;
            flags_q  <= flags_d;
            taken_q  <= taken_d;
            pc_q     <= pc_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_result   = result_q;
    assign out_opcode   = opcode_q;
    assign out_rd       = rd_q;
    assign out_wb_en    = wb_en_q;
    assign flag_z       = flags_q.z;
    assign flag_v       = flags_q.v;
    assign flag_n       = flags_q.n;
    assign branch_taken = taken_q;
    assign branch_pc    = pc_q;

endmodule : ex_mem_stage
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Self-checking bench for ex_mem_stage with a behavioural
//                reference model of the stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, stall, flush;
    logic [31:0] alu_result;
    logic        alu_z, alu_v, alu_n;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic        wb_en, set_flags, br_en;
    logic [2:0]  br_cond;
    logic [31:0] br_target;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_opcode;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        flag_z, flag_v, flag_n;
    logic        branch_taken;
    logic [31:0] branch_pc;

    int total = 0;
    int bad   = 0;

    // Reference state
    bit        m_valid, m_wb, m_tk;
    bit [31:0] m_res, m_pc;
    bit [4:0]  m_opc, m_rd;
    bit [2:0]  m_flags;   // {z, v, n}

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_result(alu_result), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
        .opcode(opcode), .rd(rd), .wb_en(wb_en), .set_flags(set_flags),
        .br_en(br_en), .br_cond(br_cond), .br_target(br_target),
        .out_valid(out_valid), .out_result(out_result), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_wb_en(out_wb_en), .flag_z(flag_z), .flag_v(flag_v),
        .flag_n(flag_n), .branch_taken(branch_taken), .branch_pc(branch_pc)
    );

    // Condition table written straight from the architectural definition
    function automatic bit cond_ref(input int c, input bit [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".wb_en"}, {31'd0, out_wb_en}, {31'd0, m_wb});
        chk({tag, ".taken"}, {31'd0, branch_taken}, {31'd0, m_tk});
        chk({tag, ".flags"}, {29'd0, flag_z, flag_v, flag_n}, {29'd0, m_flags});
        if (m_valid) begin
            chk({tag, ".result"}, out_result, m_res);
            chk({tag, ".opcode"}, {27'd0, out_opcode}, {27'd0, m_opc});
            chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, m_rd});
        end
        if (m_tk) chk({tag, ".pc"}, branch_pc, m_pc);
    endtask

    task automatic model_reset();
        m_valid = 0; m_wb = 0; m_tk = 0; m_res = 0; m_pc = 0;
        m_opc = 0; m_rd = 0; m_flags = 3'b000;
    endtask

    task automatic idle();
        in_valid = 0; stall = 0; flush = 0; alu_result = 0;
        alu_z = 0; alu_v = 0; alu_n = 0; opcode = 0; rd = 0;
        wb_en = 0; set_flags = 0; br_en = 0; br_cond = 0; br_target = 0;
    endtask

    // Advance the model by one edge using the inputs currently driven,
    // then clock the DUT and compare just after the edge.
    task automatic step(input string tag);
        if (flush) begin
            m_valid = 0; m_wb = 0; m_tk = 0;
        end else if (!stall) begin
            if (in_valid) begin
                m_valid = 1; m_res = alu_result; m_opc = opcode; m_rd = rd;
                m_wb = wb_en;
                m_tk = br_en && cond_ref(int'(br_cond), m_flags);
                if (br_en) m_pc = br_target;
                if (set_flags) m_flags = {alu_z, alu_v, alu_n};
            end else begin
                m_valid = 0; m_wb = 0; m_tk = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1;
        #1;
        check_all("reset_init");
        @(posedge clk); #1;
        rst = 0;

        // Load flags=111 and a valid instruction, then reset mid-cycle
        in_valid = 1; set_flags = 1; alu_z = 1; alu_v = 1; alu_n = 1;
        alu_result = 32'h1234_5678; wb_en = 1; rd = 5'd3; opcode = 5'h01;
        step("pre_reset");
        #3; rst = 1; #1;
        model_reset();
        check_all("reset_async");
        #1; rst = 0;
        idle();
        step("after_reset");

        // Pass-through
        in_valid = 1; alu_result = 32'hDEADBEEF; rd = 5'd7; wb_en = 1; opcode = 5'h02;
        step("pass");

        // Flags then branch (EQ taken, then NE not taken)
        idle(); in_valid = 1; set_flags = 1; alu_z = 1;
        step("setz");
        idle(); in_valid = 1; br_en = 1; br_cond = 3'b001; br_target = 32'h100;
        step("br_eq");
        chk("br_eq_taken", {31'd0, branch_taken}, 32'd1);
        chk("br_eq_pc", branch_pc, 32'h100);
        br_cond = 3'b000;
        step("br_ne");
        chk("br_ne_taken", {31'd0, branch_taken}, 32'd0);

        // Same-cycle set_flags + branch sees the old flags
        idle(); in_valid = 1; set_flags = 1;
        step("clr_flags");
        idle(); in_valid = 1; set_flags = 1; alu_z = 1; br_en = 1; br_cond = 3'b001;
        br_target = 32'h200;
        step("same_cycle");
        chk("same_cycle_taken", {31'd0, branch_taken}, 32'd0);
        chk("same_cycle_z", {31'd0, flag_z}, 32'd1);

        // Stall for 3 cycles then flush during stall with a flag setter
        idle(); in_valid = 1; alu_result = 32'hCAFE_0001; rd = 5'd9; wb_en = 1;
        br_en = 1; br_cond = 3'b111; br_target = 32'h300;
        step("pre_stall");
        stall = 1; alu_result = 32'h0BAD_0BAD; rd = 5'd1; br_target = 32'h400;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall_result", out_result, 32'hCAFE_0001);
        chk("stall_taken", {31'd0, branch_taken}, 32'd1);
        flush = 1; set_flags = 1; alu_n = 1;
        step("flush");
        chk("flush_n", {31'd0, flag_n}, 32'd0);

        // Reset while a redirect is pending: no redirect after release
        idle(); in_valid = 1; br_en = 1; br_cond = 3'b111; br_target = 32'h500;
        step("pre_rst_br");
        stall = 1;
        #3; rst = 1; #1;
        model_reset();
        check_all("rst_mid_branch");
        #1; rst = 0;
        idle();
        step("post_rst_br");

        // Sweep all condition codes over all flag combinations
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                idle(); in_valid = 1; set_flags = 1;
                alu_z = f[2]; alu_v = f[1]; alu_n = f[0];
                step("sweep_set");
                idle(); in_valid = 1; br_en = 1; br_cond = 3'(c);
                br_target = 32'(f * 8 + c);
                step("sweep_br");
            end
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom % 4) != 0;
            stall      = ($urandom % 5) == 0;
            flush      = ($urandom % 7) == 0;
            alu_result = $urandom;
            {alu_z, alu_v, alu_n} = 3'($urandom);
            opcode     = 5'($urandom);
            rd         = 5'($urandom);
            wb_en      = 1'($urandom);
            set_flags  = 1'($urandom);
            br_en      = 1'($urandom);
            br_cond    = 3'($urandom);
            br_target  = $urandom;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ex_mem_stage
`default_nettype wire
